// File: rtl/msxbus_pkg.sv
// Shared types and constants for the MSX cartridge-bus cycle engine.
package msxbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAITST = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic MIO_MEM  = 1'b0;
    localparam logic MIO_IO   = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msxbus_if.sv
// Host request/response and MSX edge-pin bundle for the bus engine.
// Slot index is wide enough to also express out-of-range slot numbers.
interface msxbus_if #(
    parameter int AW    = 16,
    parameter int NSLOT = 2
);
    localparam int SW = $clog2(NSLOT + 1);

    logic          host_req;
    logic          host_mio;
    logic          host_rw;
    logic [SW-1:0] host_slot;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_ack;
    logic          host_err;
    logic          busy;

    logic [AW-1:0]    maddr;
    logic [7:0]       mdata_i;
    logic [7:0]       mdata_o;
    logic             mdata_oe;
    logic [NSLOT-1:0] msltsl_n;
    logic             mmreq_n;
    logic             miorq_n;
    logic             mrd_n;
    logic             mwr_n;
    logic             mwait_n;
    logic             msx_clk;

    // Engine side
    modport master (
        input  host_req, host_mio, host_rw, host_slot, host_addr, host_wdata,
        output host_rdata, host_ack, host_err, busy,
        output maddr, mdata_o, mdata_oe, msltsl_n, mmreq_n, miorq_n, mrd_n, mwr_n, msx_clk,
        input  mdata_i, mwait_n
    );

    // Host / cartridge side
    modport slave (
        output host_req, host_mio, host_rw, host_slot, host_addr, host_wdata,
        input  host_rdata, host_ack, host_err, busy,
        input  maddr, mdata_o, mdata_oe, msltsl_n, mmreq_n, miorq_n, mrd_n, mwr_n, msx_clk,
        output mdata_i, mwait_n
    );

endinterface

// File: rtl/msxbus_clkgen.sv
// Free-running MSX bus clock divider: msx_clk toggles every CLKDIV clk cycles.
module msx_clkgen #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic msx_clk
);
    localparam int DW = $clog2(CLKDIV) + 1;

    logic [DW-1:0] div_q, div_d;
    logic          msx_clk_q, msx_clk_d;

    // Next divider count and toggle decision
    always_comb begin
        div_d     = div_q + 1'b1;
        msx_clk_d = msx_clk_q;
        if (div_q == DW'(CLKDIV - 1)) begin
            div_d     = '0;
            msx_clk_d = ~msx_clk_q;
        end
    end

    // Divider state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            msx_clk_q <= 1'b1;
        end else begin
            div_q     <= div_d;
            msx_clk_q <= msx_clk_d;
        end
    end

    assign msx_clk = msx_clk_q;

endmodule

// File: rtl/msxbus_engine.sv
// MSX cartridge-bus cycle engine: one host request becomes a timed
// setup / strobe / WAIT-stretch / hold bus cycle, finished by a one-cycle ack.
module msxbus_engine
    import msxbus_pkg::*;
#(
    parameter int AW       = 16,
    parameter int NSLOT    = 2,
    parameter int CLKDIV   = 4,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 3,
    parameter int T_HOLD   = 1,
    parameter int WAIT_TO  = 255
) (
    input logic       clk,
    input logic       rst_n,
    msxbus_if.master  bus
);
    localparam int SW = $clog2(NSLOT + 1);
    localparam int CW = $clog2(max3(T_SETUP, T_STROBE, T_HOLD)) + 1;
    localparam int WW = $clog2(WAIT_TO) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             mio_q, mio_d;
    logic             rw_q, rw_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic             err_q, err_d;
    logic [AW-1:0]    maddr_q, maddr_d;
    logic [7:0]       mdata_o_q, mdata_o_d;
    logic             oe_q, oe_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [NSLOT-1:0] msltsl_n_q, msltsl_n_d;
    logic             mmreq_n_q, mmreq_n_d;
    logic             miorq_n_q, miorq_n_d;
    logic             mrd_n_q, mrd_n_d;
    logic             mwr_n_q, mwr_n_d;
    logic [1:0]       wsync_q;
    logic             wait_s;
    logic             bad_slot;
    logic             leave;
    logic             msx_clk_w;

    assign wait_s   = wsync_q[1];
    assign bad_slot = ({1'b0, bus.host_slot} >= (SW + 1)'(NSLOT));

    msx_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .msx_clk (msx_clk_w)
    );

    // Two-stage synchroniser for the asynchronous WAIT input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsync_q <= 2'b11;
        end else begin
            wsync_q <= {wsync_q[0], bus.mwait_n};
        end
    end

    // Next-state and registered-output logic for the bus cycle FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        mio_d      = mio_q;
        rw_d       = rw_q;
        slot_d     = slot_q;
        err_d      = err_q;
        maddr_d    = maddr_q;
        mdata_o_d  = mdata_o_q;
        oe_d       = oe_q;
        rdata_d    = rdata_q;
        msltsl_n_d = msltsl_n_q;
        mmreq_n_d  = mmreq_n_q;
        miorq_n_d  = miorq_n_q;
        mrd_n_d    = mrd_n_q;
        mwr_n_d    = mwr_n_q;
        leave      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.host_req) begin
                    mio_d   = bus.host_mio;
                    rw_d    = bus.host_rw;
                    slot_d  = bus.host_slot;
                    maddr_d = bus.host_addr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (bus.host_mio == MIO_MEM && bad_slot) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        if (bus.host_rw == RW_WRITE) begin
                            oe_d      = 1'b1;
                            mdata_o_d = bus.host_wdata;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(T_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                    if (mio_q == MIO_IO) begin
                        miorq_n_d = 1'b0;
                    end else begin
                        mmreq_n_d = 1'b0;
                        for (int unsigned i = 0; i < NSLOT; i++) begin
                            if (slot_q == SW'(i)) msltsl_n_d[i] = 1'b0;
                        end
                    end
                    if (rw_q == RW_READ) mrd_n_d = 1'b0;
                    else                 mwr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == CW'(T_STROBE - 1)) begin
                    cnt_d = '0;
                    if (!wait_s) begin
                        wcnt_d  = '0;
                        state_d = ST_WAITST;
                    end else begin
                        leave = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAITST: begin
                if (wait_s) begin
                    leave = 1'b1;
                end else if (wcnt_q == WW'(WAIT_TO - 1)) begin
                    err_d = 1'b1;
                    leave = 1'b1;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(T_HOLD - 1)) begin
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving the strobe phase: release every strobe, capture read data
        if (leave) begin
            msltsl_n_d = '1;
            mmreq_n_d  = 1'b1;
            miorq_n_d  = 1'b1;
            mrd_n_d    = 1'b1;
            mwr_n_d    = 1'b1;
            cnt_d      = '0;
            state_d    = ST_HOLD;
            if (rw_q == RW_READ) rdata_d = bus.mdata_i;
        end
    end

    // FSM state and bus-pin registers; reset releases strobes asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            mio_q      <= MIO_MEM;
            rw_q       <= RW_WRITE;
            slot_q     <= '0;
            err_q      <= 1'b0;
            maddr_q    <= '0;
            mdata_o_q  <= '0;
            oe_q       <= 1'b0;
            rdata_q    <= '0;
            msltsl_n_q <= '1;
            mmreq_n_q  <= 1'b1;
            miorq_n_q  <= 1'b1;
            mrd_n_q    <= 1'b1;
            mwr_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            mio_q      <= mio_d;
            rw_q       <= rw_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
            maddr_q    <= maddr_d;
            mdata_o_q  <= mdata_o_d;
            oe_q       <= oe_d;
            rdata_q    <= rdata_d;
            msltsl_n_q <= msltsl_n_d;
            mmreq_n_q  <= mmreq_n_d;
            miorq_n_q  <= miorq_n_d;
            mrd_n_q    <= mrd_n_d;
            mwr_n_q    <= mwr_n_d;
        end
    end

    assign bus.host_rdata = rdata_q;
    assign bus.host_ack   = (state_q == ST_DONE);
    assign bus.host_err   = (state_q == ST_DONE) && err_q;
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.maddr      = maddr_q;
    assign bus.mdata_o    = mdata_o_q;
    assign bus.mdata_oe   = oe_q;
    assign bus.msltsl_n   = msltsl_n_q;
    assign bus.mmreq_n    = mmreq_n_q;
    assign bus.miorq_n    = miorq_n_q;
    assign bus.mrd_n      = mrd_n_q;
    assign bus.mwr_n      = mwr_n_q;
    assign bus.msx_clk    = msx_clk_w;

endmodule

// File: tb/tb_msxbus_engine.sv
// Scoreboard bench for msxbus_engine: each scenario task drives requests,
// pushes the expected response, and compares it when host_ack arrives.
module tb_msxbus_engine;
    import msxbus_pkg::*;

    localparam int AW       = 16;
    localparam int NSLOT    = 2;
    localparam int CLKDIV   = 4;
    localparam int T_SETUP  = 1;
    localparam int T_STROBE = 3;
    localparam int T_HOLD   = 1;
    localparam int WAIT_TO  = 255;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       chk_rdata;
    } exp_t;

    typedef struct {
        logic       timeout;
        int         cyc;
        int         rd;
        int         wr;
        int         mreq;
        int         iorq;
        logic [1:0] slot_and;
        logic       strobed;
        logic       data_bad;
        logic       addr_bad;
        int         hold_cnt;
        int         hold_oe;
        logic [7:0] rdata;
        logic       err;
        logic       busy;
        logic       oe;
        logic       idle_pins;
    } obs_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];

    msxbus_if #(.AW(AW), .NSLOT(NSLOT)) bus ();

    msxbus_engine #(
        .AW(AW), .NSLOT(NSLOT), .CLKDIV(CLKDIV), .T_SETUP(T_SETUP),
        .T_STROBE(T_STROBE), .T_HOLD(T_HOLD), .WAIT_TO(WAIT_TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic issue(input logic mio, input logic rw, input logic [1:0] slot,
                         input logic [15:0] addr, input logic [7:0] wd);
        @(negedge clk);
        bus.host_mio   = mio;
        bus.host_rw    = rw;
        bus.host_slot  = slot;
        bus.host_addr  = addr;
        bus.host_wdata = wd;
        bus.host_req   = 1'b1;
    endtask

    // Samples once per cycle (negedge) until host_ack or the cycle limit; iteration 0 follows the accept edge.
    task automatic wait_ack(input int limit, input int wstart, input int wlen,
                            input logic [7:0] wexp, input logic [15:0] aexp,
                            input logic drop_req, input logic scramble, output obs_t o);
        o = '{timeout: 1'b1, slot_and: 2'b11, default: 0};
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (i == 0 && drop_req) bus.host_req = 1'b0;
            if (i == 1 && scramble) begin
                bus.host_addr  = ~bus.host_addr;
                bus.host_wdata = ~bus.host_wdata;
            end
            if (i == wstart)        bus.mwait_n = 1'b0;
            if (i == wstart + wlen) bus.mwait_n = 1'b1;
            if (!bus.mrd_n) o.rd++;
            if (!bus.mwr_n) begin
                o.wr++;
                if (bus.mdata_o !== wexp || bus.mdata_oe !== 1'b1) o.data_bad = 1'b1;
            end
            if (!bus.mmreq_n) o.mreq++;
            if (!bus.miorq_n) o.iorq++;
            if (!bus.mrd_n || !bus.mwr_n) begin
                o.strobed  = 1'b1;
                o.slot_and = o.slot_and & bus.msltsl_n;
                if (bus.maddr !== aexp) o.addr_bad = 1'b1;
            end
            if (o.strobed && bus.mrd_n && bus.mwr_n && !bus.host_ack) begin
                o.hold_cnt++;
                if (bus.mdata_oe) o.hold_oe++;
                if (bus.maddr !== aexp) o.addr_bad = 1'b1;
            end
            if (bus.host_ack) begin
                o.timeout   = 1'b0;
                o.cyc       = i + 1;
                o.rdata     = bus.host_rdata;
                o.err       = bus.host_err;
                o.busy      = bus.busy;
                o.oe        = bus.mdata_oe;
                o.idle_pins = bus.mrd_n & bus.mwr_n & bus.mmreq_n & bus.miorq_n & (&bus.msltsl_n);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.host_req   = 1'b0;
        bus.host_mio   = MIO_MEM;
        bus.host_rw    = RW_READ;
        bus.host_slot  = '0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.mdata_i    = '0;
        bus.mwait_n    = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.maddr !== 16'h0 || bus.mdata_o !== 8'h0 || bus.mdata_oe !== 1'b0) begin
            bad++; $display("FAIL reset_bus got maddr=%h mdata_o=%h oe=%b exp 0000/00/0", bus.maddr, bus.mdata_o, bus.mdata_oe);
        end
        total++;
        if ({bus.msltsl_n, bus.mmreq_n, bus.miorq_n, bus.mrd_n, bus.mwr_n} !== 6'b111111) begin
            bad++; $display("FAIL reset_strobes got %b exp 111111", {bus.msltsl_n, bus.mmreq_n, bus.miorq_n, bus.mrd_n, bus.mwr_n});
        end
        total++;
        if (bus.host_rdata !== 8'h0 || bus.host_ack !== 1'b0 || bus.host_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_host got rdata=%h ack=%b err=%b busy=%b exp 00/0/0/0", bus.host_rdata, bus.host_ack, bus.host_err, bus.busy);
        end
        total++;
        if (bus.msx_clk !== 1'b1) begin
            bad++; $display("FAIL reset_msx_clk got %b exp 1", bus.msx_clk);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 4 * CLKDIV; k++) begin
            @(negedge clk);
            total++;
            if (bus.msx_clk !== logic'(((k / CLKDIV) % 2) == 0)) begin
                bad++; $display("FAIL divider k=%0d got %b exp %b", k, bus.msx_clk, ((k / CLKDIV) % 2) == 0);
            end
        end
    endtask

    task automatic test_mem_read();
        obs_t o; exp_t e;
        bus.mdata_i = 8'hA5;
        exp_q.push_back('{rdata: 8'hA5, err: 1'b0, chk_rdata: 1'b1});
        issue(MIO_MEM, RW_READ, 2'd1, 16'h4000, 8'h00);
        wait_ack(64, -1, 0, 8'h00, 16'h4000, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout) begin bad++; $display("FAIL mem_read_ack got timeout exp ack"); end
        total++;
        if (o.rdata !== e.rdata || o.err !== e.err) begin
            bad++; $display("FAIL mem_read_resp got rdata=%h err=%b exp %h/%b", o.rdata, o.err, e.rdata, e.err);
        end
        total++;
        if (o.rd != T_STROBE || o.mreq != T_STROBE || o.iorq != 0 || o.wr != 0) begin
            bad++; $display("FAIL mem_read_strobes got rd=%0d mreq=%0d iorq=%0d wr=%0d exp %0d/%0d/0/0", o.rd, o.mreq, o.iorq, o.wr, T_STROBE, T_STROBE);
        end
        total++;
        if (o.slot_and !== 2'b01 || o.addr_bad) begin
            bad++; $display("FAIL mem_read_slot got msltsl_n=%b addr_bad=%b exp 01/0", o.slot_and, o.addr_bad);
        end
        total++;
        if (o.cyc != T_SETUP + T_STROBE + T_HOLD + 1 || o.busy !== 1'b0) begin
            bad++; $display("FAIL mem_read_timing got cyc=%0d busy=%b exp %0d/0", o.cyc, o.busy, T_SETUP + T_STROBE + T_HOLD + 1);
        end
    endtask

    task automatic test_io_write();
        obs_t o; exp_t e;
        exp_q.push_back('{rdata: 8'h00, err: 1'b0, chk_rdata: 1'b0});
        issue(MIO_IO, RW_WRITE, 2'd0, 16'h0098, 8'h3C);
        wait_ack(64, -1, 0, 8'h3C, 16'h0098, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.err !== e.err) begin bad++; $display("FAIL io_write_ack got timeout=%b err=%b exp 0/%b", o.timeout, o.err, e.err); end
        total++;
        if (o.wr != T_STROBE || o.iorq != T_STROBE || o.mreq != 0 || o.rd != 0) begin
            bad++; $display("FAIL io_write_strobes got wr=%0d iorq=%0d mreq=%0d rd=%0d exp %0d/%0d/0/0", o.wr, o.iorq, o.mreq, o.rd, T_STROBE, T_STROBE);
        end
        total++;
        if (o.slot_and !== 2'b11 || o.data_bad || o.addr_bad) begin
            bad++; $display("FAIL io_write_bus got msltsl_n=%b data_bad=%b addr_bad=%b exp 11/0/0", o.slot_and, o.data_bad, o.addr_bad);
        end
        total++;
        if (o.hold_cnt != T_HOLD || o.hold_oe != T_HOLD || o.oe !== 1'b0) begin
            bad++; $display("FAIL io_write_hold got hold=%0d hold_oe=%0d oe_at_ack=%b exp %0d/%0d/0", o.hold_cnt, o.hold_oe, o.oe, T_HOLD, T_HOLD);
        end
    endtask

    task automatic test_wait_stretch();
        obs_t o; exp_t e;
        bus.mdata_i = 8'h5E;
        exp_q.push_back('{rdata: 8'h5E, err: 1'b0, chk_rdata: 1'b1});
        issue(MIO_MEM, RW_READ, 2'd0, 16'h1234, 8'h00);
        wait_ack(100, 1, 10, 8'h00, 16'h1234, 1'b1, 1'b0, o);
        bus.mwait_n = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.err !== e.err || o.rdata !== e.rdata) begin
            bad++; $display("FAIL wait_resp got timeout=%b err=%b rdata=%h exp 0/%b/%h", o.timeout, o.err, o.rdata, e.err, e.rdata);
        end
        total++;
        if (o.rd < 12 || o.rd > 14 || o.slot_and !== 2'b10) begin
            bad++; $display("FAIL wait_stretch got rd=%0d msltsl_n=%b exp 12..14/10", o.rd, o.slot_and);
        end
    endtask

    task automatic test_wait_timeout();
        obs_t o; exp_t e;
        bus.mdata_i = 8'hC3;
        exp_q.push_back('{rdata: 8'hC3, err: 1'b1, chk_rdata: 1'b1});
        issue(MIO_MEM, RW_READ, 2'd1, 16'h7FFF, 8'h00);
        wait_ack(400, 1, 100000, 8'h00, 16'h7FFF, 1'b1, 1'b0, o);
        bus.mwait_n = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.err !== e.err || o.rdata !== e.rdata) begin
            bad++; $display("FAIL timeout_resp got timeout=%b err=%b rdata=%h exp 0/%b/%h", o.timeout, o.err, o.rdata, e.err, e.rdata);
        end
        total++;
        if (o.rd != T_STROBE + WAIT_TO || o.idle_pins !== 1'b1) begin
            bad++; $display("FAIL timeout_len got rd=%0d idle_pins=%b exp %0d/1", o.rd, o.idle_pins, T_STROBE + WAIT_TO);
        end
    endtask

    task automatic test_bad_slot();
        obs_t o; exp_t e;
        exp_q.push_back('{rdata: 8'h00, err: 1'b1, chk_rdata: 1'b0});
        issue(MIO_MEM, RW_WRITE, 2'd2, 16'h2000, 8'h77);
        wait_ack(8, -1, 0, 8'h77, 16'h2000, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.err !== e.err || o.cyc > 2) begin
            bad++; $display("FAIL bad_slot_resp got timeout=%b err=%b cyc=%0d exp 0/%b/<=2", o.timeout, o.err, o.cyc, e.err);
        end
        total++;
        if (o.rd + o.wr + o.mreq + o.iorq != 0 || o.slot_and !== 2'b11 || o.oe !== 1'b0) begin
            bad++; $display("FAIL bad_slot_bus got rd=%0d wr=%0d mreq=%0d iorq=%0d oe=%b exp no activity", o.rd, o.wr, o.mreq, o.iorq, o.oe);
        end
    endtask

    task automatic test_reset_mid_cycle();
        obs_t o; exp_t e;
        issue(MIO_MEM, RW_READ, 2'd0, 16'h0100, 8'h00);
        @(negedge clk);
        bus.host_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mrd_n !== 1'b0 || bus.mmreq_n !== 1'b0) begin
            bad++; $display("FAIL midrst_pre got mrd_n=%b mmreq_n=%b exp 0/0", bus.mrd_n, bus.mmreq_n);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.msltsl_n, bus.mmreq_n, bus.miorq_n, bus.mrd_n, bus.mwr_n} !== 6'b111111 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_release got pins=%b busy=%b exp 111111/0", {bus.msltsl_n, bus.mmreq_n, bus.miorq_n, bus.mrd_n, bus.mwr_n}, bus.busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (bus.host_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack k=%0d got %b exp 0", k, bus.host_ack); end
        end
        rst_n = 1'b1;
        bus.mdata_i = 8'h96;
        exp_q.push_back('{rdata: 8'h96, err: 1'b0, chk_rdata: 1'b1});
        issue(MIO_MEM, RW_READ, 2'd0, 16'h0200, 8'h00);
        wait_ack(64, -1, 0, 8'h00, 16'h0200, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.rdata !== e.rdata || o.err !== e.err || o.rd != T_STROBE) begin
            bad++; $display("FAIL midrst_after got timeout=%b rdata=%h err=%b rd=%0d exp 0/%h/%b/%0d", o.timeout, o.rdata, o.err, o.rd, e.rdata, e.err, T_STROBE);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        bus.mdata_i = 8'h11;
        exp_q.push_back('{rdata: 8'h11, err: 1'b0, chk_rdata: 1'b1});
        issue(MIO_MEM, RW_READ, 2'd1, 16'h8000, 8'h00);
        wait_ack(64, -1, 0, 8'h00, 16'h8000, 1'b0, 1'b1, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.rdata !== e.rdata || o.addr_bad) begin
            bad++; $display("FAIL b2b_first got timeout=%b rdata=%h addr_bad=%b exp 0/%h/0", o.timeout, o.rdata, o.addr_bad, e.rdata);
        end
        bus.host_addr = 16'h8001;
        bus.mdata_i   = 8'h22;
        exp_q.push_back('{rdata: 8'h22, err: 1'b0, chk_rdata: 1'b1});
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.host_ack !== 1'b0) begin
            bad++; $display("FAIL b2b_gap got busy=%b ack=%b exp 0/0", bus.busy, bus.host_ack);
        end
        wait_ack(64, -1, 0, 8'h00, 16'h8001, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        total++;
        if (o.timeout || o.rdata !== e.rdata || o.err !== e.err || o.cyc != T_SETUP + T_STROBE + T_HOLD + 1) begin
            bad++; $display("FAIL b2b_second got timeout=%b rdata=%h err=%b cyc=%0d exp 0/%h/%b/%0d", o.timeout, o.rdata, o.err, o.cyc, e.rdata, e.err, T_SETUP + T_STROBE + T_HOLD + 1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_stretch();
        test_wait_timeout();
        test_bad_slot();
        test_reset_mid_cycle();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
